// File: rtl/front_pipe_ctrl.sv
// Front-end pipeline control: per-stage Stall/Flush for IF_ID, ID_RN, RN_DS and PC hold,
// with rename-map recovery sequencing, exception drain wait and a saturating stall counter.
package System_Pkg;
  typedef struct packed {
    logic Clk;
    logic Rst;
  } Global;

  typedef struct packed {
    logic Stall;
    logic Flush;
  } Local;
endpackage

module front_pipe_ctrl
  import System_Pkg::*;
#(
  parameter int unsigned RECOVER_CYC = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  Global              System,
  input  logic               Rn_Busy,
  input  logic               Br_Redirect,
  input  logic               Exc_Req,
  input  logic               Exc_Done,
  input  logic               Stall_Clr,
  output Local               IF_ID_Cntl,
  output Local               ID_RN_Cntl,
  output Local               RN_DS_Cntl,
  output logic               PC_Hold,
  output logic               Recovering,
  output logic [CNT_W-1:0]   Stall_Cnt
);

  localparam logic [3:0] RcInit = 4'(RECOVER_CYC);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StRecover = 2'd1,
    StExcWait = 2'd2
  } state_e;

  logic w_clk;
  logic w_rst;
  assign w_clk = System.Clk;
  assign w_rst = System.Rst;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [3:0]       r_rc;
  logic [3:0]       w_rc_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state <= StRun;
      r_rc    <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_rc    <= w_rc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rc_nxt    = r_rc;
    IF_ID_Cntl  = '0;
    ID_RN_Cntl  = '0;
    RN_DS_Cntl  = '0;
    PC_Hold     = 1'b0;
    Recovering  = 1'b0;

    unique case (r_state)
      StRun: begin
        if (Exc_Req) begin
          IF_ID_Cntl.Flush = 1'b1;
          ID_RN_Cntl.Flush = 1'b1;
          RN_DS_Cntl.Flush = 1'b1;
          w_state_nxt      = StExcWait;
        end else if (Br_Redirect) begin
          IF_ID_Cntl.Flush = 1'b1;
          ID_RN_Cntl.Flush = 1'b1;
          RN_DS_Cntl.Flush = 1'b1;
          w_rc_nxt         = RcInit;
          w_state_nxt      = StRecover;
        end else if (Rn_Busy) begin
          // Hold upstream, push a bubble into dispatch so nothing is issued twice.
          IF_ID_Cntl.Stall = 1'b1;
          ID_RN_Cntl.Stall = 1'b1;
          RN_DS_Cntl.Flush = 1'b1;
          PC_Hold          = 1'b1;
        end
      end

      StRecover: begin
        Recovering = 1'b1;
        if (Exc_Req) begin
          IF_ID_Cntl.Flush = 1'b1;
          ID_RN_Cntl.Flush = 1'b1;
          RN_DS_Cntl.Flush = 1'b1;
          w_state_nxt      = StExcWait;
        end else if (Br_Redirect) begin
          IF_ID_Cntl.Flush = 1'b1;
          ID_RN_Cntl.Flush = 1'b1;
          RN_DS_Cntl.Flush = 1'b1;
          w_rc_nxt         = RcInit;
        end else begin
          IF_ID_Cntl.Stall = 1'b1;
          ID_RN_Cntl.Stall = 1'b1;
          RN_DS_Cntl.Flush = 1'b1;
          PC_Hold          = 1'b1;
          w_rc_nxt         = r_rc - 4'd1;
          if (r_rc == 4'd1) begin
            w_state_nxt = StRun;
          end
        end
      end

      StExcWait: begin
        IF_ID_Cntl.Flush = 1'b1;
        ID_RN_Cntl.Flush = 1'b1;
        RN_DS_Cntl.Flush = 1'b1;
        if (Exc_Req) begin
          // A fresh exception reloads the vector while the drain continues.
          PC_Hold = 1'b0;
        end else begin
          PC_Hold = 1'b1;
          if (Exc_Done) begin
            w_state_nxt = StRun;
          end
        end
      end

      default: begin
        w_state_nxt = StRun;
      end
    endcase

    if (w_rst) begin
      IF_ID_Cntl = '{Stall: 1'b0, Flush: 1'b1};
      ID_RN_Cntl = '{Stall: 1'b0, Flush: 1'b1};
      RN_DS_Cntl = '{Stall: 1'b0, Flush: 1'b1};
      PC_Hold    = 1'b1;
      Recovering = 1'b0;
    end
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_stall_cnt <= '0;
    end else if (Stall_Clr) begin
      r_stall_cnt <= '0;
    end else if (ID_RN_Cntl.Stall && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign Stall_Cnt = r_stall_cnt;

endmodule

// File: tb/tb_front_pipe_ctrl.sv
// Randomized bench for front_pipe_ctrl against a cycle-indexed behavioural model.
module tb_front_pipe_ctrl;
  import System_Pkg::*;

  localparam int unsigned RC    = 2;
  localparam int unsigned CW    = 4;
  localparam int          CMax  = (1 << CW) - 1;
  localparam int          MRun  = 0;
  localparam int          MRec  = 1;
  localparam int          MExc  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  Global sys;
  logic rn_busy = 1'b0, br = 1'b0, exc = 1'b0, exc_done = 1'b0, clr = 1'b0;
  Local if_c, id_c, rn_c;
  logic pc_hold, recovering;
  logic [CW-1:0] stall_cnt;

  assign sys = {clk, rst};
  always #5 clk = ~clk;

  front_pipe_ctrl #(
    .RECOVER_CYC(RC),
    .CNT_W      (CW)
  ) u_dut (
    .System     (sys),
    .Rn_Busy    (rn_busy),
    .Br_Redirect(br),
    .Exc_Req    (exc),
    .Exc_Done   (exc_done),
    .Stall_Clr  (clr),
    .IF_ID_Cntl (if_c),
    .ID_RN_Cntl (id_c),
    .RN_DS_Cntl (rn_c),
    .PC_Hold    (pc_hold),
    .Recovering (recovering),
    .Stall_Cnt  (stall_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: current mode, cycle index, cycle at which recovery finishes, stall count.
  int m_mode  = MRun;
  int m_cyc   = 0;
  int m_until = 0;
  int m_cnt   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // {IF.Stall, IF.Flush, ID.Stall, ID.Flush, RN.Stall, RN.Flush, PC_Hold, Recovering}
  function automatic logic [7:0] got_ctl();
    return {if_c.Stall, if_c.Flush, id_c.Stall, id_c.Flush, rn_c.Stall, rn_c.Flush,
            pc_hold, recovering};
  endfunction

  function automatic logic [7:0] exp_ctl(input logic b, input logic r, input logic e);
    logic [7:0] flush_all = 8'b0101_0100;
    logic [7:0] stall_bub = 8'b1010_0110;
    logic [7:0] v;
    v = 8'h00;
    case (m_mode)
      MRun: begin
        if (e || r)  v = flush_all;
        else if (b)  v = stall_bub;
      end
      MRec: begin
        v = (e || r) ? flush_all : stall_bub;
        v[0] = 1'b1;
      end
      default: begin
        v = flush_all;
        v[1] = !e;
      end
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_mode = MRun;
    m_cnt  = 0;
  endtask

  // Called just after a negedge; returns just after the following negedge.
  task automatic step(input logic b, input logic r, input logic e, input logic d,
                      input logic c);
    logic [7:0] exp;
    rn_busy = b; br = r; exc = e; exc_done = d; clr = c;
    #1;
    exp = exp_ctl(b, r, e);
    check_eq("ctl", 32'(got_ctl()), 32'(exp));
    check_eq("cnt", 32'(stall_cnt), 32'(m_cnt));
    @(posedge clk);
    if (c) m_cnt = 0;
    else if (exp[5] && m_cnt < CMax) m_cnt++;
    case (m_mode)
      MRun: begin
        if (e) m_mode = MExc;
        else if (r) begin m_mode = MRec; m_until = m_cyc + RC; end
      end
      MRec: begin
        if (e) m_mode = MExc;
        else if (r) m_until = m_cyc + RC;
        else if (m_cyc >= m_until) m_mode = MRun;
      end
      default: if (!e && d) m_mode = MRun;
    endcase
    m_cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset pulse in mid-cycle; outputs must switch without waiting for a clock.
  task automatic async_reset();
    rn_busy = 1'b0; br = 1'b0; exc = 1'b0; exc_done = 1'b0; clr = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_ctl", 32'(got_ctl()), 32'h56);
    check_eq("rst_cnt", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #1;
    check_eq("por_ctl", 32'(got_ctl()), 32'h56);
    check_eq("por_cnt", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    idle(3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    check_eq("busy5_cnt", 32'(stall_cnt), 32'd5);

    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);

    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);

    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("sat_cnt", 32'(stall_cnt), 32'(CMax));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("clr_cnt", 32'(stall_cnt), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    async_reset();
    idle(2);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    async_reset();
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        step(1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 10),
             1'($urandom_range(0, 99) < 5),  1'($urandom_range(0, 99) < 30),
             1'($urandom_range(0, 99) < 5));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
